// File: rtl/rng_pkg.sv
// Shared constants, types and helpers for the random-number scheduler.
// Holds the LFSR width, feedback taps, FSM state encoding and default seed.
package rng_pkg;

    localparam int LFSR_W = 10;
    localparam int TAP_A  = 9;
    localparam int TAP_B  = 6;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 10'h001;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } rng_state_e;

    // One Fibonacci step of x^10 + x^7 + 1 (period 1023, never reaches zero).
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] r);
        return {r[LFSR_W-2:0], r[TAP_A] ^ r[TAP_B]};
    endfunction

endpackage

// File: rtl/rng_lfsr10.sv
// 10-bit Fibonacci LFSR with load and step enables.
// Load wins over step; the caller guarantees a non-zero load value.
module rng_lfsr10
    import rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_en,
    input  logic              load_en,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next LFSR value: load has priority, otherwise step when enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_en) begin
            lfsr_d = load_val;
        end else if (step_en) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // LFSR register, reset to the configured seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/rng_scheduler.sv
// Round-robin scheduler handing out LFSR values to NUM_REQ requesters.
// Optional per-requester grant statistics are enabled by defining
// RNG_SCHED_STATS_EN (adds stat_sel / stat_cnt ports).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_WARM | discarding WARMUP LFSR steps after reset/reseed, no grants
//   ST_RUN  | arbitrating requests, one grant + random value per cycle
module rng_scheduler
    import rng_pkg::*;
#(
    parameter int                NUM_REQ = 4,
    parameter int                WARMUP  = 16,
    parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       seed_valid,
    input  logic [LFSR_W-1:0]          seed_data,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [LFSR_W-1:0]          rand_out,
    output logic                       ready
`ifdef RNG_SCHED_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [15:0]                stat_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    rng_state_e        state_q, state_d;
    logic [7:0]        warm_cnt_q, warm_cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [LFSR_W-1:0] rand_q, rand_d;

    logic              lfsr_step_en;
    logic [LFSR_W-1:0] lfsr_val;
    logic [LFSR_W-1:0] seed_eff;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;

    // A zero seed would lock the LFSR, so it is replaced by SEED.
    assign seed_eff = (seed_data == '0) ? SEED : seed_data;

    rng_lfsr10 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_en  (lfsr_step_en),
        .load_en  (seed_valid),
        .load_val (seed_eff),
        .state    (lfsr_val)
    );

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // FSM next state, grant/value generation and LFSR stepping control.
    always_comb begin
        state_d      = state_q;
        warm_cnt_d   = warm_cnt_q;
        ptr_d        = ptr_q;
        gnt_d        = '0;
        rand_d       = rand_q;
        lfsr_step_en = 1'b0;
        if (seed_valid) begin
            // Reseed beats any grant; the pointer is deliberately kept.
            state_d    = ST_WARM;
            warm_cnt_d = '0;
        end else begin
            case (state_q)
                ST_WARM: begin
                    lfsr_step_en = 1'b1;
                    warm_cnt_d   = warm_cnt_q + 8'd1;
                    if (warm_cnt_d == 8'(WARMUP)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (win_found) begin
                        gnt_d[win_idx] = 1'b1;
                        rand_d         = lfsr_val;
                        lfsr_step_en   = 1'b1;
                        ptr_d          = win_idx;
                    end
                end
                default: begin
                    state_d = ST_WARM;
                end
            endcase
        end
    end

    // Scheduler registers; reset clears outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WARM;
            warm_cnt_q <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            gnt_q      <= '0;
            rand_q     <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rand_q     <= rand_d;
        end
    end

    assign gnt      = gnt_q;
    assign rand_out = rand_q;
    assign ready    = (state_q == ST_RUN);

`ifdef RNG_SCHED_STATS_EN
    logic [15:0] gcnt_q [NUM_REQ];
    logic [15:0] gcnt_d [NUM_REQ];

    // Saturating grant counters, counted on the edge that issues the grant.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            gcnt_d[i] = gcnt_q[i];
            if (gnt_d[i] && (gcnt_q[i] != 16'hFFFF)) begin
                gcnt_d[i] = gcnt_q[i] + 16'd1;
            end
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gcnt_q[i] <= gcnt_d[i];
            end
        end
    end

    // Selected counter; out-of-range selects read as zero.
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(stat_sel) == i) begin
                stat_cnt = gcnt_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_rng_scheduler.sv
// Self-checking bench for rng_scheduler with a behavioural reference model.
// Covers the stat counters too when RNG_SCHED_STATS_EN is defined.
module tb_rng_scheduler;

    localparam int N  = 4;
    localparam int WU = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         seed_valid = 1'b0;
    logic [9:0]   seed_data = '0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [9:0]   rand_out;
    logic         ready;
`ifdef RNG_SCHED_STATS_EN
    logic [1:0]   stat_sel = '0;
    logic [15:0]  stat_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_lfsr;
    int m_warm_left;
    int m_ptr;
    int m_gnt;
    int m_rand;

    always #5 clk = ~clk;

    rng_scheduler #(
        .NUM_REQ (N),
        .WARMUP  (WU),
        .SEED    (10'h001)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .req        (req),
        .gnt        (gnt),
        .rand_out   (rand_out),
        .ready      (ready)
`ifdef RNG_SCHED_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_cnt   (stat_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int next_rand(input int r);
        int fb;
        fb = ((r >> 9) & 1) ^ ((r >> 6) & 1);
        return ((r * 2) % 1024) + fb;
    endfunction

    task automatic model_reset();
        m_lfsr      = 1;
        m_warm_left = WU;
        m_ptr       = N - 1;
        m_gnt       = 0;
        m_rand      = 0;
    endtask

    task automatic model_edge(input bit sv, input int sd, input int rq);
        m_gnt = 0;
        if (sv) begin
            m_lfsr      = (sd == 0) ? 1 : sd;
            m_warm_left = WU;
        end else if (m_warm_left > 0) begin
            m_lfsr = next_rand(m_lfsr);
            m_warm_left--;
        end else if (rq != 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_gnt == 0 && ((rq >> c) & 1) == 1) begin
                    m_gnt = 1 << c;
                    m_ptr = c;
                end
            end
            m_rand = m_lfsr;
            m_lfsr = next_rand(m_lfsr);
        end
    endtask

    task automatic cmp_model();
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("rand_out", 32'(rand_out), 32'(m_rand));
        chk("ready", 32'(ready), 32'(m_warm_left == 0));
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic cyc(input bit sv, input logic [9:0] sd, input logic [N-1:0] rq);
        seed_valid = sv;
        seed_data  = sd;
        req        = rq;
        @(posedge clk);
        model_edge(sv, int'(sd), int'(rq));
        #1;
        cmp_model();
        seed_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input logic [N-1:0] rq);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            cyc(1'b0, '0, rq);
            n++;
        end
        chk(tag, 32'(n), 32'(WU));
    endtask

    initial begin
        logic [3:0] exp_g [5];
        logic [9:0] exp_r [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_r = '{10'h244, 10'h088, 10'h110, 10'h220, 10'h041};

        model_reset();
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rand", 32'(rand_out), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Warm-up length after reset
        wait_ready("warm_len_reset", '0);

        // All requesting: rotate through every requester
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, 4'b1111);
            chk("rr_gnt", 32'(gnt), 32'(exp_g[i]));
            chk("rr_rand", 32'(rand_out), 32'(exp_r[i]));
        end

        // Single requester wins repeatedly
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 4'b0100);
            chk("solo_gnt", 32'(gnt), 32'h4);
        end
        cyc(1'b0, '0, 4'b0000);
        chk("idle_gnt", 32'(gnt), 32'd0);

        // Zero reseed coincident with a request: no grant, fresh warm-up
        cyc(1'b1, 10'h000, 4'b0001);
        chk("seed_no_gnt", 32'(gnt), 32'd0);
        chk("seed_ready", 32'(ready), 32'd0);
        wait_ready("warm_len_seed", 4'b0001);
        cyc(1'b0, '0, 4'b0001);
        chk("seed_gnt", 32'(gnt), 32'h1);
        chk("seed_rand", 32'(rand_out), 32'h244);

        // Reset in the middle of a grant
        cyc(1'b0, '0, 4'b0010);
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_rand", 32'(rand_out), 32'd0);
        chk("async_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("warm_len_rst2", '0);
        cyc(1'b0, '0, 4'b1111);
        chk("post_rst_gnt", 32'(gnt), 32'h1);

        // Randomized traffic with occasional reseeds
        for (int i = 0; i < 600; i++) begin
            bit         sv;
            logic [9:0] sd;
            sv = ($urandom_range(0, 39) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom);
            cyc(sv, sd, N'($urandom));
        end

`ifdef RNG_SCHED_STATS_EN
        // Saturation of one requester's grant counter
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("warm_len_stat", '0);
        for (int i = 0; i < 70000; i++) begin
            cyc(1'b0, '0, 4'b0010);
        end
        stat_sel = 2'd1;
        #1;
        chk("stat_sat", 32'(stat_cnt), 32'hFFFF);
        for (int s = 0; s < N; s++) begin
            if (s != 1) begin
                stat_sel = 2'(s);
                #1;
                chk("stat_zero", 32'(stat_cnt), 32'd0);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
